// File: rtl/riscv_mem_stage_pkg.sv
// Shared types and constants for the memory-access stage: load/store size codes,
// handshake FSM states and the register-file widths.
package riscv_mem_stage_pkg;

   localparam int REG_W      = 32;
   localparam int REG_ADDR_W = 5;

   localparam logic [2:0] LS_B  = 3'b000;
   localparam logic [2:0] LS_H  = 3'b001;
   localparam logic [2:0] LS_W  = 3'b010;
   localparam logic [2:0] LS_BU = 3'b100;
   localparam logic [2:0] LS_HU = 3'b101;

   typedef enum logic [1:0] {
      MEM_IDLE = 2'd0,
      MEM_REQ  = 2'd1,
      MEM_WAIT = 2'd2
   } mem_state_e;

   // Collapses funct3 to 0 = byte, 1 = half, 2 = word; unknown codes behave as word.
   function automatic logic [1:0] accessSize(input logic [2:0] funct3);
      case (funct3)
         LS_B, LS_BU: accessSize = 2'd0;
         LS_H, LS_HU: accessSize = 2'd1;
         LS_W:        accessSize = 2'd2;
         default:     accessSize = 2'd2;
      endcase
   endfunction

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane steering for the data bus: store byte enables and replicated write data,
// load lane select with sign/zero extension, and misalignment detection.
module riscv_lsu_align
   import riscv_mem_stage_pkg::*;
(
   input  logic [2:0]       i_funct3,
   input  logic [1:0]       i_lane,
   input  logic [REG_W-1:0] i_storeData,
   input  logic [31:0]      i_rdata,
   output logic [3:0]       o_be,
   output logic [31:0]      o_wdata,
   output logic [REG_W-1:0] o_loadData,
   output logic             o_misaligned
);

   logic [1:0]  w_size;
   logic [31:0] w_shifted;

   assign w_size    = accessSize(i_funct3);
   assign w_shifted = i_rdata >> {i_lane, 3'b000};

   // funct3[2] marks the unsigned load variants, so it suppresses the sign fill.
   always_comb begin
      o_be         = 4'b1111;
      o_wdata      = i_storeData;
      o_loadData   = w_shifted;
      o_misaligned = 1'b0;
      case (w_size)
         2'd0: begin
            o_be       = 4'b0001 << i_lane;
            o_wdata    = {4{i_storeData[7:0]}};
            o_loadData = {{24{~i_funct3[2] & w_shifted[7]}}, w_shifted[7:0]};
         end
         2'd1: begin
            o_be         = 4'b0011 << i_lane;
            o_wdata      = {2{i_storeData[15:0]}};
            o_loadData   = {{16{~i_funct3[2] & w_shifted[15]}}, w_shifted[15:0]};
            o_misaligned = i_lane[0];
         end
         default: begin
            o_misaligned = |i_lane;
         end
      endcase
   end

endmodule

// File: rtl/riscv_mem_stage.sv
// MEM pipeline stage: drives the data-memory request/grant/response handshake,
// stalls upstream while a transaction is outstanding and forwards results to MEM/WB.
module riscv_mem_stage
   import riscv_mem_stage_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  MemRd_in,
   input  logic                  MemWr_in,
   input  logic                  MemtoReg_in,
   input  logic                  RegWr_in,
   input  logic [2:0]            funct3_in,
   input  logic [REG_W-1:0]      AluP_val_in,
   input  logic [REG_W-1:0]      MemWr_val_in,
   input  logic [REG_ADDR_W-1:0] rd_idx_in,
   output logic                  dmem_req,
   output logic                  dmem_we,
   output logic [3:0]            dmem_be,
   output logic [ADDR_W-1:0]     dmem_addr,
   output logic [31:0]           dmem_wdata,
   input  logic                  dmem_gnt,
   input  logic                  dmem_rvalid,
   input  logic [31:0]           dmem_rdata,
   output logic                  MemtoReg_out,
   output logic                  RegWr_out,
   output logic [REG_W-1:0]      AluP_val_out,
   output logic [REG_W-1:0]      MemRd_val_out,
   output logic [REG_ADDR_W-1:0] rd_idx_out,
   output logic                  stall_req,
   output logic                  misaligned
);

   mem_state_e r_state;
   mem_state_e w_nextState;

   logic             w_memOp;
   logic             w_misaligned;
   logic             w_validOp;
   logic             w_complete;
   logic [REG_W-1:0] w_loadData;

   riscv_lsu_align u_align (
      .i_funct3     (funct3_in),
      .i_lane       (AluP_val_in[1:0]),
      .i_storeData  (MemWr_val_in),
      .i_rdata      (dmem_rdata),
      .o_be         (dmem_be),
      .o_wdata      (dmem_wdata),
      .o_loadData   (w_loadData),
      .o_misaligned (w_misaligned)
   );

   assign w_memOp   = MemRd_in | MemWr_in;
   assign w_validOp = w_memOp & ~w_misaligned;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= MEM_IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Request fields come straight from the EX/MEM inputs, which stay frozen by stall_req
   // until completion; responses outside WAIT are never consumed.
   always_comb begin
      w_nextState = r_state;
      dmem_req    = 1'b0;
      w_complete  = 1'b0;
      case (r_state)
         MEM_IDLE: begin
            if (w_validOp) begin
               dmem_req    = 1'b1;
               w_nextState = dmem_gnt ? MEM_WAIT : MEM_REQ;
            end
         end
         MEM_REQ: begin
            dmem_req = 1'b1;
            if (dmem_gnt) begin
               w_nextState = MEM_WAIT;
            end
         end
         MEM_WAIT: begin
            if (dmem_rvalid) begin
               w_complete  = 1'b1;
               w_nextState = MEM_IDLE;
            end
         end
         default: begin
            w_nextState = MEM_IDLE;
         end
      endcase
   end

   assign dmem_we       = dmem_req & MemWr_in;
   assign dmem_addr     = {AluP_val_in[ADDR_W-1:2], 2'b00};
   assign stall_req     = w_validOp & ~w_complete;
   assign misaligned    = w_memOp & w_misaligned;
   assign MemtoReg_out  = MemtoReg_in;
   assign RegWr_out     = RegWr_in & ~misaligned;
   assign AluP_val_out  = AluP_val_in;
   assign rd_idx_out    = rd_idx_in;
   assign MemRd_val_out = (w_complete & MemRd_in) ? w_loadData : '0;

endmodule
